temperature_analyzer: RTL and testbench

- Clocked classifier for patient body-temperature samples (unsigned integer °C) in the health-care monitoring datapath.
- Flags each valid sample as low, normal or high against a fixed normal band.
- Drives a persistence-filtered abnormality alarm and a saturating alarm-event counter, which feed the downstream alert/aggregation logic.

---
 rtl/temperature_analyzer.sv | 85 ++++++++
 tb/tb_temperature_analyzer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/temperature_analyzer.sv
// ---------------------------------------------------------------------------
// temperature_analyzer
//   Classifies body-temperature samples (unsigned degrees C) as low, normal or
//   high. It drives an alarm that needs PERSIST consecutive abnormal samples
//   to raise, and a saturating counter of alarm rising edges.
//
// Ports
//   clk                      system clock, rising edge
//   rst_n                    asynchronous active-low reset
//   sample_valid             temperature is valid this cycle
//   temperature[DATA_W]      unsigned sample
//   clear                    synchronous clear of alarm state and counter
//   too_low                  last valid sample < LOW_LIMIT
//   too_high                 last valid sample > HIGH_LIMIT
//   temperature_abnormality  persistence-filtered alarm
//   alarm_count[CNT_W]       number of alarm rising edges, saturating
// ---------------------------------------------------------------------------
module temperature_analyzer #(
    parameter int DATA_W     = 8,
    parameter int LOW_LIMIT  = 35,
    parameter int HIGH_LIMIT = 39,
    parameter int PERSIST    = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] temperature,
    input  logic              clear,
    output logic              too_low,
    output logic              too_high,
    output logic              temperature_abnormality,
    output logic [CNT_W-1:0]  alarm_count
);

    localparam logic [DATA_W-1:0] LOW_L   = DATA_W'(LOW_LIMIT);
    localparam logic [DATA_W-1:0] HIGH_L  = DATA_W'(HIGH_LIMIT);
    localparam logic [7:0]        PERSIST_C = 8'(PERSIST);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic       is_low;
    logic       is_high;
    logic [7:0] persist_cnt;
    logic [7:0] persist_next;
    logic       reach;

    assign is_low  = temperature < LOW_L;
    assign is_high = temperature > HIGH_L;

    // The counter saturates at PERSIST, so it can never step past the limit.
    assign persist_next = (persist_cnt == PERSIST_C) ? PERSIST_C : persist_cnt + 8'd1;
    assign reach        = (persist_next == PERSIST_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            too_low                 <= 1'b0;
            too_high                <= 1'b0;
            temperature_abnormality <= 1'b0;
            alarm_count             <= '0;
            persist_cnt             <= '0;
        end else if (clear) begin
            // A sample arriving alongside clear is dropped.
            too_low                 <= 1'b0;
            too_high                <= 1'b0;
            temperature_abnormality <= 1'b0;
            alarm_count             <= '0;
            persist_cnt             <= '0;
        end else if (sample_valid) begin
            too_low  <= is_low;
            too_high <= is_high;
            if (is_low || is_high) begin
                persist_cnt <= persist_next;
                if (reach && !temperature_abnormality) begin
                    temperature_abnormality <= 1'b1;
                    if (alarm_count != '1)
                        alarm_count <= alarm_count + CNT_ONE;
                end
            end else begin
                persist_cnt             <= '0;
                temperature_abnormality <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_temperature_analyzer.sv
// ---------------------------------------------------------------------------
// tb_temperature_analyzer
//   Drives three instances with the same stimulus:
//     u_p1 : defaults (PERSIST=1, CNT_W=16)
//     u_p3 : PERSIST=3
//     u_c4 : CNT_W=4 (saturation)
//   Each instance is checked against a run-length reference model. A vector
//   table and hand-written sequences also check against literal expectations.
// ---------------------------------------------------------------------------
module tb_temperature_analyzer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_valid = 1'b0;
    logic [7:0] temperature = '0;
    logic       clear = 1'b0;

    logic        lo [3];
    logic        hi [3];
    logic        ab [3];
    logic [15:0] cnt1, cnt3;
    logic [3:0]  cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    temperature_analyzer u_p1 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .temperature(temperature),
        .clear(clear), .too_low(lo[0]), .too_high(hi[0]),
        .temperature_abnormality(ab[0]), .alarm_count(cnt1));

    temperature_analyzer #(.PERSIST(3)) u_p3 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .temperature(temperature),
        .clear(clear), .too_low(lo[1]), .too_high(hi[1]),
        .temperature_abnormality(ab[1]), .alarm_count(cnt3));

    temperature_analyzer #(.CNT_W(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .temperature(temperature),
        .clear(clear), .too_low(lo[2]), .too_high(hi[2]),
        .temperature_abnormality(ab[2]), .alarm_count(cnt4));

    // Reference model: length of the current abnormal run, alarm = run >= P
    int m_p   [3] = '{1, 3, 1};
    int m_max [3] = '{65535, 65535, 15};
    int m_run [3];
    int m_cnt [3];
    bit m_al  [3];
    bit m_lo  [3];
    bit m_hi  [3];

    function automatic int dut_cnt(int k);
        case (k)
            0:       return int'(cnt1);
            1:       return int'(cnt3);
            default: return int'(cnt4);
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_run[k] = 0; m_cnt[k] = 0; m_al[k] = 0; m_lo[k] = 0; m_hi[k] = 0;
        end
    endtask

    task automatic model_step(bit v, int t, bit c);
        for (int k = 0; k < 3; k++) begin
            if (c) begin
                m_run[k] = 0; m_cnt[k] = 0; m_al[k] = 0; m_lo[k] = 0; m_hi[k] = 0;
            end else if (v) begin
                bit new_al;
                m_lo[k] = (t < 35);
                m_hi[k] = (t > 39);
                if (m_lo[k] || m_hi[k]) m_run[k] = (m_run[k] < 1000) ? m_run[k] + 1 : 1000;
                else                    m_run[k] = 0;
                new_al = (m_run[k] >= m_p[k]);
                if (new_al && !m_al[k] && m_cnt[k] < m_max[k]) m_cnt[k]++;
                m_al[k] = new_al;
            end
        end
    endtask

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s[%0d].too_low", tag, k),  int'(lo[k]), int'(m_lo[k]));
            check($sformatf("%s[%0d].too_high", tag, k), int'(hi[k]), int'(m_hi[k]));
            check($sformatf("%s[%0d].abn", tag, k),      int'(ab[k]), int'(m_al[k]));
            check($sformatf("%s[%0d].count", tag, k),    dut_cnt(k),  m_cnt[k]);
        end
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after rising.
    task automatic step(bit v, int t, bit c, string tag);
        @(negedge clk);
        sample_valid = v;
        temperature  = 8'(t);
        clear        = c;
        @(posedge clk);
        #1;
        model_step(v, t, c);
        check_model(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; sample_valid = 1'b0; clear = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int t;
        bit e_lo, e_hi, e_ab;
        int e_cnt;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // Expectations for the PERSIST=1 instance, in order after reset.
        vecs.push_back('{2,   1, 0, 1, 1});
        vecs.push_back('{36,  0, 0, 0, 1});
        vecs.push_back('{34,  1, 0, 1, 2});
        vecs.push_back('{35,  0, 0, 0, 2});
        vecs.push_back('{39,  0, 0, 0, 2});
        vecs.push_back('{40,  0, 1, 1, 3});
        vecs.push_back('{255, 0, 1, 1, 3});
        vecs.push_back('{0,   1, 0, 1, 3});
        vecs.push_back('{37,  0, 0, 0, 3});

        do_reset();
        #1;
        check_model("reset");
        check("reset.count", int'(cnt1), 0);

        // Vector table
        foreach (vecs[i]) begin
            step(1, vecs[i].t, 0, "tbl");
            check($sformatf("tbl%0d.too_low", i),  int'(lo[0]), int'(vecs[i].e_lo));
            check($sformatf("tbl%0d.too_high", i), int'(hi[0]), int'(vecs[i].e_hi));
            check($sformatf("tbl%0d.abn", i),      int'(ab[0]), int'(vecs[i].e_ab));
            check($sformatf("tbl%0d.count", i),    int'(cnt1),  vecs[i].e_cnt);
        end

        // Persistence of 3 on u_p3
        step(0, 0, 1, "clr");
        step(1, 41, 0, "p3a");
        check("p3.first41.abn", int'(ab[1]), 0);
        step(1, 41, 0, "p3b");
        check("p3.second41.abn", int'(ab[1]), 0);
        step(1, 41, 0, "p3c");
        check("p3.third41.abn", int'(ab[1]), 1);
        check("p3.third41.count", int'(cnt3), 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 10, 0, "hold");
            check("p3.hold.abn", int'(ab[1]), 1);
            check("p3.hold.too_high", int'(hi[1]), 1);
        end
        step(1, 37, 0, "p3n");
        check("p3.normal.abn", int'(ab[1]), 0);
        check("p3.normal.count", int'(cnt3), 1);

        // Low-to-high swing counts as consecutive abnormal
        step(1, 20, 0, "sw1");
        step(1, 60, 0, "sw2");
        step(1, 20, 0, "sw3");
        check("p3.swing.abn", int'(ab[1]), 1);
        check("p3.swing.count", int'(cnt3), 2);

        // Clear wins over a simultaneous valid sample
        step(1, 10, 1, "clrv");
        check("clrv.abn", int'(ab[0]), 0);
        check("clrv.too_low", int'(lo[0]), 0);
        check("clrv.count", int'(cnt1), 0);

        // Asynchronous reset in the middle of a cycle
        step(1, 2, 0, "pre");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model("arst");
        check("arst.too_low", int'(lo[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Counter saturation on CNT_W=4
        for (int i = 0; i < 21; i++) begin
            step(1, 2, 0, "satL");
            step(1, 36, 0, "satN");
        end
        check("sat.c4", int'(cnt4), 15);
        check("sat.c16", int'(cnt1), 21);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            bit v, c;
            int t;
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 40) == 0);
            t = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(32, 42));
            step(v, t, c, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
